spi_slave_burst: RTL and testbench

Parametrised SPI mode-0 slave, successor to the single-frame slave. It adds multi-word burst transfers with address auto-increment, read prefetch, and partial-word abort handling. It sits between the external SPI pins and the on-chip register file, clocked entirely by `sclk`. One header (RW + address) is followed by any number of data words while `ss_n` stays low.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_tx_shifter.sv | 44 ++++
 rtl/spi_slave_burst.sv | 191 +++++++++++++++++++
 tb/tb_spi_slave_burst.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the burst SPI slave: RW encoding,
//               frame state enumeration and header length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // First header bit selects the transfer direction.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } spi_state_t;

    // Header = RW bit followed by the register address.
    function automatic int hdr_bits(input int addr_bits);
        return 1 + addr_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_shifter
// Description : Negedge-clocked MISO shift register. The posedge domain asks
//               for a parallel load by toggling load_tgl; this block loads
//               data_in on the next negedge and records the toggle as its
//               acknowledge. On every other negedge it shifts left by one.
// Ports       : sclk     - SPI clock (logic runs on the falling edge)
//               rst_n    - asynchronous active-low reset
//               load_tgl - load request toggle from the posedge domain
//               data_in  - parallel word to load
//               ser_out  - current MSB of the shifter
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_shifter #(
    parameter int DATA_BITS = 8
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    input  logic                 load_tgl,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ser_out
);

    logic                 r_ack;
    logic [DATA_BITS-1:0] r_shift;

    always_ff @(negedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_shift <= '0;
        end else if (load_tgl != r_ack) begin
            // A pending request is a toggle that has not been echoed yet.
            r_ack   <= load_tgl;
            r_shift <= data_in;
        end else begin
            r_shift <= {r_shift[DATA_BITS-2:0], 1'b0};
        end
    end

    assign ser_out = r_shift[DATA_BITS-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_burst.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_burst
// Description : SPI mode-0 slave with multi-word bursts. One header (RW +
//               address) is followed by any number of data words while ss_n
//               stays low. Writes strobe write_enable at each word's last
//               posedge; reads prefetch the next word via rd_req so the TX
//               shifter can reload on the following negedge.
// Ports       : sclk, rst_n       - SPI clock, async active-low reset
//               ss_n, mosi, miso  - SPI pins (miso high-Z while ss_n = 1)
//               addr_out          - address of current write/read request
//               data_out          - write data
//               write_enable      - one-period write strobe
//               rd_req            - one-period read request for addr_out
//               data_in           - read data from the register file
//               done              - one-period pulse per completed word
//               word_cnt          - completed words, saturating at MAX_BURST
//               burst_active      - header seen, frame still open
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_burst
    import spi_pkg::*;
#(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = 16,
    parameter int AUTO_INC  = 1
) (
    input  logic                           sclk,
    input  logic                           rst_n,
    input  logic                           ss_n,
    input  logic                           mosi,
    output logic                           miso,
    output logic [ADDR_BITS-1:0]           addr_out,
    output logic [DATA_BITS-1:0]           data_out,
    output logic                           write_enable,
    output logic                           rd_req,
    input  logic [DATA_BITS-1:0]           data_in,
    output logic                           done,
    output logic [$clog2(MAX_BURST+1)-1:0] word_cnt,
    output logic                           burst_active
);

    localparam int c_HDR_BITS = hdr_bits(ADDR_BITS);
    localparam int c_RX_W     = (c_HDR_BITS > DATA_BITS) ? c_HDR_BITS : DATA_BITS;
    localparam int c_CNT_W    = $clog2(c_RX_W + 1);
    localparam int c_WC_W     = $clog2(MAX_BURST + 1);

    spi_state_t           r_state;
    spi_state_t           w_state_next;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    // Holds all but the newest bit; w_rx_next appends the bit being sampled.
    logic [c_RX_W-2:0]    r_rx;
    logic [c_RX_W-1:0]    w_rx_next;
    logic                 r_rw;
    logic [ADDR_BITS-1:0] r_addr;
    logic [ADDR_BITS-1:0] w_addr_inc;
    logic                 r_load_tgl;
    logic                 w_hdr_last;
    logic                 w_word_last;
    logic                 w_tx_bit;

    generate
        if (AUTO_INC != 0) begin : g_auto_inc
            // Natural ADDR_BITS overflow gives the modulo wrap.
            assign w_addr_inc = r_addr + 1'b1;
        end else begin : g_fixed_addr
            assign w_addr_inc = r_addr;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_rx_next    = {r_rx, mosi};
        w_hdr_last   = (r_state == HDR)  && (r_bit_cnt == c_CNT_W'(c_HDR_BITS - 1));
        w_word_last  = (r_state == DATA) && (r_bit_cnt == c_CNT_W'(DATA_BITS - 1));
        w_state_next = r_state;
        if (ss_n) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = HDR;
                HDR:     if (w_hdr_last) w_state_next = DATA;
                default: w_state_next = DATA;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Posedge datapath: RX shifter, bit counter, address counter, strobes
    // ------------------------------------------------------------------
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_rx         <= '0;
            r_rw         <= RW_WRITE;
            r_addr       <= '0;
            r_load_tgl   <= 1'b0;
            addr_out     <= '0;
            data_out     <= '0;
            write_enable <= 1'b0;
            rd_req       <= 1'b0;
            done         <= 1'b0;
            word_cnt     <= '0;
            burst_active <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            rd_req       <= 1'b0;
            done         <= 1'b0;
            if (ss_n) begin
                // Any partial header or word is simply dropped here.
                r_bit_cnt    <= '0;
                word_cnt     <= '0;
                burst_active <= 1'b0;
            end else begin
                r_rx <= w_rx_next[c_RX_W-2:0];
                case (r_state)
                    IDLE: begin
                        // The selecting edge already carries header bit 0.
                        r_bit_cnt <= c_CNT_W'(1);
                    end
                    HDR: begin
                        if (w_hdr_last) begin
                            r_bit_cnt    <= '0;
                            r_rw         <= w_rx_next[c_HDR_BITS-1];
                            r_addr       <= w_rx_next[ADDR_BITS-1:0];
                            addr_out     <= w_rx_next[ADDR_BITS-1:0];
                            burst_active <= 1'b1;
                            if (w_rx_next[c_HDR_BITS-1] == RW_READ) begin
                                rd_req     <= 1'b1;
                                r_load_tgl <= ~r_load_tgl;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (w_word_last) begin
                            r_bit_cnt <= '0;
                            done      <= 1'b1;
                            r_addr    <= w_addr_inc;
                            if (word_cnt != c_WC_W'(MAX_BURST)) begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                            if (r_rw == RW_WRITE) begin
                                data_out     <= w_rx_next[DATA_BITS-1:0];
                                addr_out     <= r_addr;
                                write_enable <= 1'b1;
                            end else begin
                                // Prefetch the next word; reload happens on
                                // the coming negedge.
                                addr_out   <= w_addr_inc;
                                rd_req     <= 1'b1;
                                r_load_tgl <= ~r_load_tgl;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Negedge TX path
    // ------------------------------------------------------------------
    spi_tx_shifter #(
        .DATA_BITS (DATA_BITS)
    ) u_tx (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .load_tgl (r_load_tgl),
        .data_in  (data_in),
        .ser_out  (w_tx_bit)
    );

    assign miso = ss_n ? 1'bz : w_tx_bit;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_burst
// Description : Scoreboard bench for spi_slave_burst. Instance A uses the
//               default parameters; instance B has AUTO_INC=0, MAX_BURST=2.
//               Frame tasks push hand-computed expectations into queues and
//               drive the pins; negedge monitors pop and compare whenever a
//               strobe appears, and a posedge monitor assembles MISO bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_burst;

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    logic sclk   = 1'b0;
    logic rst_n  = 1'b0;
    logic mosi   = 1'b0;
    logic ss_n_a = 1'b1;
    logic ss_n_b = 1'b1;

    always #5 sclk = ~sclk;

    wire        miso_a, miso_b;
    logic [6:0] addr_a, addr_b;
    logic [7:0] dout_a, dout_b;
    logic       we_a, we_b, rd_a, rd_b, done_a, done_b, ba_a, ba_b;
    logic [4:0] wc_a;
    logic [1:0] wc_b;
    logic [7:0] din_a;
    logic [7:0] din_b;

    // Register-file model: read data is the inverted address.
    assign din_a = {1'b0, addr_a} ^ 8'hFF;
    assign din_b = 8'h00;

    spi_slave_burst #(.ADDR_BITS(7), .DATA_BITS(8), .MAX_BURST(16), .AUTO_INC(1)) dut_a (
        .sclk(sclk), .rst_n(rst_n), .ss_n(ss_n_a), .mosi(mosi), .miso(miso_a),
        .addr_out(addr_a), .data_out(dout_a), .write_enable(we_a), .rd_req(rd_a),
        .data_in(din_a), .done(done_a), .word_cnt(wc_a), .burst_active(ba_a)
    );

    spi_slave_burst #(.ADDR_BITS(7), .DATA_BITS(8), .MAX_BURST(2), .AUTO_INC(0)) dut_b (
        .sclk(sclk), .rst_n(rst_n), .ss_n(ss_n_b), .mosi(mosi), .miso(miso_b),
        .addr_out(addr_b), .data_out(dout_b), .write_enable(we_b), .rd_req(rd_b),
        .data_in(din_b), .done(done_b), .word_cnt(wc_b), .burst_active(ba_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    wr_t        q_wr_a[$];
    wr_t        q_wr_b[$];
    logic [6:0] q_rd_a[$];
    logic [4:0] q_done_a[$];
    logic [1:0] q_done_b[$];
    logic [7:0] q_miso[$];

    // Per-frame directed vectors, set by the caller.
    logic [7:0] wbuf[$];
    logic [6:0] eaddr[$];
    logic [7:0] erd[$];

    logic rd_phase = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: unexpected event, value %0h, nothing queued", nm, act);
    endtask

    // ---------------- monitors ----------------
    wr_t exp_wa, exp_wb;

    always @(negedge sclk) begin
        if (we_a) begin
            if (q_wr_a.size() == 0) unexpected("write A", 32'(addr_a));
            else begin
                exp_wa = q_wr_a.pop_front();
                chk("write addr A", 32'(addr_a), 32'(exp_wa.a));
                chk("write data A", 32'(dout_a), 32'(exp_wa.d));
            end
        end
        if (rd_a) begin
            if (q_rd_a.size() == 0) unexpected("rd_req A", 32'(addr_a));
            else chk("rd_req addr A", 32'(addr_a), 32'(q_rd_a.pop_front()));
        end
        if (done_a) begin
            if (q_done_a.size() == 0) unexpected("done A", 32'(wc_a));
            else chk("word_cnt A", 32'(wc_a), 32'(q_done_a.pop_front()));
        end
    end

    always @(negedge sclk) begin
        if (we_b) begin
            if (q_wr_b.size() == 0) unexpected("write B", 32'(addr_b));
            else begin
                exp_wb = q_wr_b.pop_front();
                chk("write addr B", 32'(addr_b), 32'(exp_wb.a));
                chk("write data B", 32'(dout_b), 32'(exp_wb.d));
            end
        end
        if (rd_b) unexpected("rd_req B", 32'(addr_b));
        if (done_b) begin
            if (q_done_b.size() == 0) unexpected("done B", 32'(wc_b));
            else chk("word_cnt B", 32'(wc_b), 32'(q_done_b.pop_front()));
        end
    end

    logic [7:0] mon_byte = 8'h00;
    int         mon_bits = 0;

    always @(posedge sclk) begin
        if (!rd_phase) begin
            mon_bits = 0;
        end else begin
            mon_byte = {mon_byte[6:0], miso_a};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (q_miso.size() == 0) unexpected("miso byte A", 32'(mon_byte));
                else chk("miso byte A", 32'(mon_byte), 32'(q_miso.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic sel_b, input logic b);
        @(negedge sclk);
        #1;
        if (sel_b) ss_n_b = 1'b0;
        else       ss_n_a = 1'b0;
        mosi = b;
    endtask

    task automatic end_frame(input logic sel_b);
        @(negedge sclk);
        #1;
        ss_n_a = 1'b1;
        ss_n_b = 1'b1;
        @(posedge sclk);
        #1;
        if (sel_b) begin
            chk("word_cnt cleared B", 32'(wc_b), 32'(0));
            chk("burst_active low B", 32'(ba_b), 32'(0));
        end else begin
            chk("word_cnt cleared A", 32'(wc_a), 32'(0));
            chk("burst_active low A", 32'(ba_a), 32'(0));
        end
        repeat (2) @(negedge sclk);
    endtask

    // nhdr header bits then ndata data bits; only full words raise events.
    task automatic frame(input logic sel_b, input logic rw, input logic [6:0] base,
                         input int nhdr, input int ndata);
        logic [7:0] hdr;
        logic       bit_v;
        int         nfull;
        hdr   = {rw, base};
        nfull = ndata / 8;
        if (nhdr == 8) begin
            if (rw) begin
                q_rd_a.push_back(eaddr[0]);
                for (int i = 0; i < nfull; i++) begin
                    q_miso.push_back(erd[i]);
                    q_rd_a.push_back(eaddr[i+1]);
                    q_done_a.push_back(5'(i + 1));
                end
            end else begin
                for (int i = 0; i < nfull; i++) begin
                    if (sel_b) begin
                        q_wr_b.push_back({eaddr[i], wbuf[i]});
                        q_done_b.push_back(2'((i + 1 > 2) ? 2 : i + 1));
                    end else begin
                        q_wr_a.push_back({eaddr[i], wbuf[i]});
                        q_done_a.push_back(5'(i + 1));
                    end
                end
            end
        end
        for (int b = 0; b < nhdr; b++) send_bit(sel_b, hdr[7-b]);
        for (int i = 0; i < ndata; i++) begin
            if (rw) bit_v = 1'b1;
            else    bit_v = wbuf[i/8][7-(i%8)];
            send_bit(sel_b, bit_v);
            if (i == 0) begin
                if (sel_b) begin
                    chk("burst_active B", 32'(ba_b), 32'(1));
                    chk("miso idle B", 32'(miso_b), 32'(0));
                end else begin
                    chk("burst_active A", 32'(ba_a), 32'(1));
                    if (rw) rd_phase = 1'b1;
                end
            end
        end
        if (ndata > 0) begin
            @(posedge sclk);
            #1;
            rd_phase = 1'b0;
        end
        end_frame(sel_b);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, " addr_out"},     32'(addr_a), 32'(0));
        chk({tag, " data_out"},     32'(dout_a), 32'(0));
        chk({tag, " write_enable"}, 32'(we_a),   32'(0));
        chk({tag, " rd_req"},       32'(rd_a),   32'(0));
        chk({tag, " done"},         32'(done_a), 32'(0));
        chk({tag, " word_cnt"},     32'(wc_a),   32'(0));
        chk({tag, " burst_active"}, 32'(ba_a),   32'(0));
    endtask

    initial begin
        logic [7:0] hdr;
        #22;
        chk_reset_a("reset");
        chk("reset write_enable B", 32'(we_b), 32'(0));
        @(negedge sclk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge sclk);

        // Single write 0xA5 to 0x05
        wbuf = '{8'hA5};             eaddr = '{7'h05};
        frame(1'b0, 1'b0, 7'h05, 8, 8);

        // Four-word burst wrapping through 0x7F -> 0x00
        wbuf  = '{8'h11, 8'h22, 8'h33, 8'h44};
        eaddr = '{7'h7E, 7'h7F, 7'h00, 7'h01};
        frame(1'b0, 1'b0, 7'h7E, 8, 32);

        // Three-word read from 0x10 with trailing prefetch of 0x13
        eaddr = '{7'h10, 7'h11, 7'h12, 7'h13};
        erd   = '{8'hEF, 8'hEE, 8'hED};
        frame(1'b0, 1'b1, 7'h10, 8, 24);

        // Fixed-address instance; word_cnt saturates at 2
        wbuf  = '{8'h01, 8'h02, 8'h03};
        eaddr = '{7'h20, 7'h20, 7'h20};
        frame(1'b1, 1'b0, 7'h20, 8, 24);

        // Abort after 5 bits of the second word: only the first write lands
        wbuf  = '{8'h5A, 8'hC3};     eaddr = '{7'h30};
        frame(1'b0, 1'b0, 7'h30, 8, 13);
        wbuf  = '{8'h3C};            eaddr = '{7'h44};
        frame(1'b0, 1'b0, 7'h44, 8, 8);

        // Partial header: outputs keep the previous write
        frame(1'b0, 1'b0, 7'h12, 4, 0);
        chk("partial hdr addr_out", 32'(addr_a), 32'(7'h44));
        chk("partial hdr data_out", 32'(dout_a), 32'(8'h3C));

        // Reset in the middle of a read word
        q_rd_a.push_back(7'h40);
        hdr = {1'b1, 7'h40};
        for (int b = 0; b < 8; b++) send_bit(1'b0, hdr[7-b]);
        repeat (3) send_bit(1'b0, 1'b1);
        chk("miso before reset", 32'(miso_a), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_reset_a("mid-read reset");
        chk("mid-read reset miso", 32'(miso_a), 32'(0));
        ss_n_a = 1'b1;
        @(negedge sclk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge sclk);

        // Fresh read after reset, wrapping 0x7F -> 0x00
        eaddr = '{7'h7F, 7'h00, 7'h01};
        erd   = '{8'h80, 8'hFF};
        frame(1'b0, 1'b1, 7'h7F, 8, 16);

        repeat (4) @(negedge sclk);
        chk("leftover writes A", 32'(q_wr_a.size()),   32'(0));
        chk("leftover writes B", 32'(q_wr_b.size()),   32'(0));
        chk("leftover rd_req A", 32'(q_rd_a.size()),   32'(0));
        chk("leftover done A",   32'(q_done_a.size()), 32'(0));
        chk("leftover done B",   32'(q_done_b.size()), 32'(0));
        chk("leftover miso A",   32'(q_miso.size()),   32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
